// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, MEM-stage FSM states and the MEM/WB bundle layout
package proc_pkg;
  localparam int WORD_W = 16;
  localparam int REG_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} memState_t;
  typedef struct packed {
    logic regWrite;
    logic [REG_W-1:0] targetReg;
    logic [WORD_W-1:0] data;
    logic memRead;
    logic memWrite;
    logic [WORD_W-1:0] memAddr;
    logic [WORD_W-1:0] memWdata;
    logic [WORD_W-1:0] memRdata;
    logic dcacheReq;
    logic dcacheHit;
    logic halt;
  } wbBundle_t;
endpackage

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg: plain W-bit register cell with asynchronous active-high clear
module mem_wb_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // capture d every cycle, clear immediately on reset
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory handshake with upstream stall, then MEM/WB bundle register
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic [REG_W-1:0]  target_reg_in,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [WORD_W-1:0] store_data_in,
  input  logic              halt_in,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_hit,
  output logic              stall_out,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_target_reg,
  output logic [WORD_W-1:0] wb_data,
  output logic              wb_mem_read,
  output logic              wb_mem_write,
  output logic [WORD_W-1:0] wb_mem_addr,
  output logic [WORD_W-1:0] wb_mem_wdata,
  output logic [WORD_W-1:0] wb_mem_rdata,
  output logic              wb_dcache_req,
  output logic              wb_dcache_hit,
  output logic              wb_halt,
  output logic              err_out,
  output logic [15:0]       stall_count
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  memState_t state;
  logic reqRd, reqWr, reqRegWrite, reqHalt;
  logic [REG_W-1:0] reqTarget;
  logic [WORD_W-1:0] reqAddr, reqWdata;
  logic [CW-1:0] waitCnt;
  logic accept, inWait, isRd, isWr, misaligned, issue, timeout, complete, err, memOk;
  logic curRd, curWr, curRegWrite, curHalt;
  logic [REG_W-1:0] curTarget;
  logic [WORD_W-1:0] curAddr, curWdata;
  wbBundle_t wbNext, wbQ;
  // request/stall decode; a store wins when both read and write are set
  always_comb begin
    accept = ~rst & (state == IDLE) & valid_in;
    inWait = ~rst & (state == WAIT);
    isWr = mem_write_in;
    isRd = mem_read_in & ~mem_write_in;
    misaligned = accept & (isRd | isWr) & alu_result_in[0];
    issue = accept & (isRd | isWr) & ~alu_result_in[0];
    timeout = inWait & ~mem_done & (waitCnt == CW'(MAX_WAIT - 1));
    complete = (accept & (~issue | mem_done)) | (inWait & (mem_done | timeout));
    err = misaligned | timeout;
    curRd = inWait ? reqRd : isRd;
    curWr = inWait ? reqWr : isWr;
    curRegWrite = inWait ? reqRegWrite : reg_write_in;
    curHalt = inWait ? reqHalt : halt_in;
    curTarget = inWait ? reqTarget : target_reg_in;
    curAddr = inWait ? reqAddr : alu_result_in;
    curWdata = inWait ? reqWdata : store_data_in;
    mem_rd = (issue | inWait) & curRd;
    mem_wr = (issue | inWait) & curWr;
    mem_addr = (issue | inWait) ? curAddr : '0;
    mem_wdata = (issue | inWait) ? curWdata : '0;
    stall_out = (issue | inWait) & ~mem_done & ~timeout;
    memOk = complete & ~err & (curRd | curWr);
  end
  // next MEM/WB bundle; anything that does not complete becomes an all-zero bubble
  always_comb begin
    wbNext = '0;
    wbNext.regWrite = complete & curRegWrite & ~err;
    wbNext.targetReg = complete ? curTarget : '0;
    wbNext.data = ~complete ? '0 : (memOk & curRd) ? mem_rdata : curAddr;
    wbNext.memRead = memOk & curRd;
    wbNext.memWrite = memOk & curWr;
    wbNext.memAddr = memOk ? curAddr : '0;
    wbNext.memWdata = (memOk & curWr) ? curWdata : '0;
    wbNext.memRdata = (memOk & curRd) ? mem_rdata : '0;
    wbNext.dcacheReq = memOk;
    wbNext.dcacheHit = memOk & mem_hit;
    wbNext.halt = complete & curHalt;
  end
  // FSM, latched request, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      {reqRd, reqWr, reqRegWrite, reqHalt} <= '0;
      reqTarget <= '0;
      reqAddr <= '0;
      reqWdata <= '0;
      waitCnt <= '0;
      err_out <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= inWait ? ((mem_done | timeout) ? (reqHalt ? HALTED : IDLE) : WAIT)
             : accept ? ((issue & ~mem_done) ? WAIT : (halt_in ? HALTED : IDLE)) : state;
      if (issue) begin
        {reqRd, reqWr, reqRegWrite, reqHalt} <= {isRd, isWr, reg_write_in, halt_in};
        reqTarget <= target_reg_in;
        reqAddr <= alu_result_in;
        reqWdata <= store_data_in;
      end
      waitCnt <= issue ? '0 : inWait ? waitCnt + 1'b1 : waitCnt;
      err_out <= err_out | err;
      stall_count <= (stall_out & ~&stall_count) ? stall_count + 16'd1 : stall_count;
    end
  mem_wb_stage_reg #(.W($bits(wbBundle_t))) wbReg (.clk(clk), .rst(rst), .d(wbNext), .q(wbQ));
  assign wb_reg_write = wbQ.regWrite;
  assign wb_target_reg = wbQ.targetReg;
  assign wb_data = wbQ.data;
  assign wb_mem_read = wbQ.memRead;
  assign wb_mem_write = wbQ.memWrite;
  assign wb_mem_addr = wbQ.memAddr;
  assign wb_mem_wdata = wbQ.memWdata;
  assign wb_mem_rdata = wbQ.memRdata;
  assign wb_dcache_req = wbQ.dcacheReq;
  assign wb_dcache_hit = wbQ.dcacheHit;
  assign wb_halt = wbQ.halt;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table vectors plus miss, misaligned, timeout, reset and halt sequences
module tb_mem_wb_stage;
  logic clk = 0, rst = 1;
  logic valid_in = 0, mem_read_in = 0, mem_write_in = 0, reg_write_in = 0, halt_in = 0;
  logic [2:0] target_reg_in = 0;
  logic [15:0] alu_result_in = 0, store_data_in = 0, mem_rdata = 0;
  logic mem_done = 0, mem_hit = 0;
  logic mem_rd, mem_wr, stall_out, wb_reg_write, wb_mem_read, wb_mem_write;
  logic wb_dcache_req, wb_dcache_hit, wb_halt, err_out;
  logic [15:0] mem_addr, mem_wdata, wb_data, wb_mem_addr, wb_mem_wdata, wb_mem_rdata, stall_count;
  logic [2:0] wb_target_reg;
  int checks = 0, failures = 0;

  mem_wb_stage #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .target_reg_in(target_reg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .halt_in(halt_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_hit(mem_hit), .stall_out(stall_out),
    .wb_reg_write(wb_reg_write), .wb_target_reg(wb_target_reg), .wb_data(wb_data),
    .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write), .wb_mem_addr(wb_mem_addr),
    .wb_mem_wdata(wb_mem_wdata), .wb_mem_rdata(wb_mem_rdata), .wb_dcache_req(wb_dcache_req),
    .wb_dcache_hit(wb_dcache_hit), .wb_halt(wb_halt), .err_out(err_out), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, rd, wr, rw;
    logic [2:0] tgt;
    logic [15:0] alu, sd, rdata;
    logic done, hit;
    logic xStall, xMemRd, xMemWr, xRw;
    logic [15:0] xData;
    logic xMemRead, xMemWrite, xReq, xHit;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, rd, wr, rw, input logic [2:0] tgt, input logic [15:0] alu, sd,
                       rdata, input logic done, hit, halt);
    valid_in = v; mem_read_in = rd; mem_write_in = wr; reg_write_in = rw; target_reg_in = tgt;
    alu_result_in = alu; store_data_in = sd; mem_rdata = rdata; mem_done = done; mem_hit = hit;
    halt_in = halt;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " mem_rd"}, mem_rd, 0);
    check({tag, " stall"}, stall_out, 0);
    check({tag, " wb_reg_write"}, wb_reg_write, 0);
    check({tag, " wb_data"}, wb_data, 0);
    check({tag, " wb_mem_read"}, wb_mem_read, 0);
    check({tag, " wb_dcache_req"}, wb_dcache_req, 0);
    check({tag, " wb_halt"}, wb_halt, 0);
    check({tag, " stall_count"}, stall_count, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1,0,0,1,3,16'h1234,16'h0,16'h0,0,0, 0,0,0,1,16'h1234,0,0,0,0};
    vecs[1] = '{1,1,0,1,5,16'h0040,16'h0,16'hBEEF,1,1, 0,1,0,1,16'hBEEF,1,0,1,1};
    vecs[2] = '{1,1,1,0,2,16'h0200,16'h5A5A,16'hDEAD,1,0, 0,0,1,0,16'h0200,0,1,1,0};
    vecs[3] = '{0,1,0,1,4,16'h0044,16'h0,16'h1111,1,1, 0,0,0,0,16'h0,0,0,0,0};
    vecs[4] = '{1,1,0,1,7,16'h0ABC,16'h0,16'h1357,1,0, 0,1,0,1,16'h1357,1,0,1,0};
    vecs[5] = '{1,0,0,0,6,16'h7777,16'h0,16'h0,1,1, 0,0,0,0,16'h7777,0,0,0,0};

    #3;
    check_idle_outputs("reset");
    check("reset err", err_out, 0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].tgt, vecs[i].alu,
            vecs[i].sd, vecs[i].rdata, vecs[i].done, vecs[i].hit, 0);
      #3;
      check($sformatf("v%0d stall", i), stall_out, vecs[i].xStall);
      check($sformatf("v%0d mem_rd", i), mem_rd, vecs[i].xMemRd);
      check($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].xMemWr);
      step();
      check($sformatf("v%0d wb_reg_write", i), wb_reg_write, vecs[i].xRw);
      check($sformatf("v%0d wb_target", i), wb_target_reg, vecs[i].valid ? vecs[i].tgt : 3'd0);
      check($sformatf("v%0d wb_data", i), wb_data, vecs[i].xData);
      check($sformatf("v%0d wb_mem_read", i), wb_mem_read, vecs[i].xMemRead);
      check($sformatf("v%0d wb_mem_write", i), wb_mem_write, vecs[i].xMemWrite);
      check($sformatf("v%0d wb_dcache_req", i), wb_dcache_req, vecs[i].xReq);
      check($sformatf("v%0d wb_dcache_hit", i), wb_dcache_hit, vecs[i].xHit);
      check($sformatf("v%0d err", i), err_out, 0);
    end
    check("table stall_count", stall_count, 0);

    drive(1, 0, 1, 0, 1, 16'h0100, 16'h00FF, 0, 0, 0, 0);
    #3;
    check("miss accept stall", stall_out, 1);
    check("miss accept mem_wr", mem_wr, 1);
    check("miss accept addr", mem_addr, 16'h0100);
    step();
    for (int i = 1; i < 4; i++) begin
      drive(0, 1, 0, 1, 5, 16'hFFFF, 16'hAAAA, 0, 0, 0, 0);
      #3;
      check($sformatf("miss w%0d stall", i), stall_out, 1);
      check($sformatf("miss w%0d mem_wr", i), mem_wr, 1);
      check($sformatf("miss w%0d addr", i), mem_addr, 16'h0100);
      check($sformatf("miss w%0d wdata", i), mem_wdata, 16'h00FF);
      step();
    end
    mem_done = 1;
    #3;
    check("miss done stall", stall_out, 0);
    check("miss done mem_wr", mem_wr, 1);
    step();
    mem_done = 0;
    check("miss wb_mem_write", wb_mem_write, 1);
    check("miss wb_mem_addr", wb_mem_addr, 16'h0100);
    check("miss wb_mem_wdata", wb_mem_wdata, 16'h00FF);
    check("miss wb_dcache_req", wb_dcache_req, 1);
    check("miss wb_dcache_hit", wb_dcache_hit, 0);
    check("miss wb_reg_write", wb_reg_write, 0);
    check("miss stall_count", stall_count, 4);
    step();
    check("miss bubble wb_mem_write", wb_mem_write, 0);

    drive(1, 1, 0, 1, 2, 16'h0041, 0, 16'h9999, 0, 0, 0);
    #3;
    check("misaligned mem_rd", mem_rd, 0);
    check("misaligned stall", stall_out, 0);
    step();
    check("misaligned err", err_out, 1);
    check("misaligned wb_reg_write", wb_reg_write, 0);

    drive(1, 1, 0, 1, 4, 16'h0300, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("pre-reset mem_rd", mem_rd, 1);
    #2 rst = 1;
    #1;
    check_idle_outputs("mid-wait reset");
    check("mid-wait reset err", err_out, 0);
    check("mid-wait reset mem_addr", mem_addr, 0);
    drive(1, 0, 0, 1, 3, 16'h1234, 0, 0, 0, 0, 0);
    #2 rst = 0;
    step();
    check("post-reset add wb_reg_write", wb_reg_write, 1);
    check("post-reset add wb_data", wb_data, 16'h1234);

    drive(1, 1, 0, 1, 1, 16'h0500, 0, 0, 0, 0, 0);
    #3;
    check("timeout accept stall", stall_out, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      if (mem_rd) n++;
      if (!stall_out) break;
      step();
    end
    check("timeout wait cycles", n, 8);
    check("timeout abort stall", stall_out, 0);
    step();
    check("timeout err", err_out, 1);
    check("timeout wb_reg_write", wb_reg_write, 0);
    check("timeout wb_mem_read", wb_mem_read, 0);
    check("timeout wb_mem_addr", wb_mem_addr, 0);
    check("timeout stall_count", stall_count, 8);
    #3;
    check("timeout dropped mem_rd", mem_rd, 0);
    step();

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    check("halt pulse", wb_halt, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 2, 16'h0040, 0, 16'hBEEF, 1, 1, i == 0);
      #3;
      check($sformatf("halted%0d mem_rd", i), mem_rd, 0);
      check($sformatf("halted%0d stall", i), stall_out, 0);
      step();
      check($sformatf("halted%0d wb_halt", i), wb_halt, 0);
      check($sformatf("halted%0d wb_reg_write", i), wb_reg_write, 0);
      check($sformatf("halted%0d wb_mem_read", i), wb_mem_read, 0);
    end
    #2 rst = 1;
    drive(1, 0, 0, 1, 6, 16'h4242, 0, 0, 0, 0, 0);
    #2 rst = 0;
    step();
    check("after halt reset wb_reg_write", wb_reg_write, 1);
    check("after halt reset wb_data", wb_data, 16'h4242);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
